// File: rtl/cmp_share_arbiter_pkg.sv
// Package for the shared comparator arbiter: FSM state encoding, comparator
// result struct, requester count and the round-robin winner pick.
package cmp_arb_pkg;

    // Number of requesters sharing the comparator.
    localparam int N_REQ = 2;

    // Arbiter FSM: pick a winner, evaluate, respond.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Comparator result, exactly one bit set for a valid result.
    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_res_t;

    // All LEDs dark: used at reset, before the first result is available.
    localparam cmp_res_t RES_NONE = '0;

    // Round-robin pick. A lone requester always wins. On a tie the requester
    // that the pointer names wins. The pointer always names the requester
    // that was not granted last.
    function automatic logic pick_winner(input logic [N_REQ-1:0] req,
                                         input logic ptr);
        logic win;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ptr;
            default: win = 1'b0;
        endcase
        return win;
    endfunction

endpackage

// File: rtl/cmp_share_arbiter_if.sv
// Requester-side bus of the shared comparator arbiter.
//
// Handshake: req[i] is a level request that holds steady, with a0/b0 or
// a1/b1 valid, until gnt[i] pulses. The gnt[i] pulse means the operands were
// captured on the edge before. The done[i] pulse comes one cycle later and
// means green/red/blue carry that requester's result. A req[i] that is still
// high once the arbiter is back in IDLE starts another transaction.
interface cmp_share_arbiter_if
    import cmp_arb_pkg::*;
#(
    parameter int W = 2
);
    logic [N_REQ-1:0] req;
    logic [W-1:0]     a0;
    logic [W-1:0]     b0;
    logic [W-1:0]     a1;
    logic [W-1:0]     b1;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] done;
    logic             green;
    logic             red;
    logic             blue;

    // Front-end side: drives requests and operands, watches grants and LEDs.
    modport master (
        output req, a0, b0, a1, b1,
        input  gnt, done, green, red, blue
    );

    // Arbiter side.
    modport slave (
        input  req, a0, b0, a1, b1,
        output gnt, done, green, red, blue
    );
endinterface

// File: rtl/cmp_share_arbiter_cmp2.sv
// cmp2_core: purely combinational unsigned magnitude comparator over W bits.
// It is the one shared resource that the arbiter hands out.
module cmp2_core
    import cmp_arb_pkg::*;
#(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output cmp_res_t     res
);

    // Unsigned compare over the full width; no sign extension.
    always_comb begin
        res    = RES_NONE;
        res.gt = (a > b);
        res.lt = (a < b);
        res.eq = (a == b);
    end

endmodule

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: shares one cmp2_core between two requesters with a
// round-robin arbiter. Operands are captured on the grant edge, compared in
// a registered stage and returned with a one-cycle done pulse plus the
// shared green/red/blue LEDs.
// Optional feature macro: CMP_ARB_STATS_EN adds saturating gt/lt/eq
// result counters on ports cnt_gt, cnt_lt and cnt_eq.
module cmp_share_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int W     = 2,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    cmp_share_arbiter_if.slave  bus,
    output arb_state_t          dbg_state
`ifdef CMP_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]    cnt_gt,
    output logic [CNT_W-1:0]    cnt_lt,
    output logic [CNT_W-1:0]    cnt_eq
`endif
);

    arb_state_t state_q;
    arb_state_t state_d;

    logic       win_d;   // requester picked this cycle, used only in IDLE
    logic       win_q;   // requester that owns the transaction in flight
    logic       ptr_q;   // requester that wins the next tie
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    cmp_res_t   core_res;
    cmp_res_t   res_q;   // registered compare result of the transaction
    cmp_res_t   led_q;   // result on display between transactions
    cmp_res_t   led_d;
    logic       start;

    assign dbg_state = state_q;

    // A new transaction begins when IDLE sees any request.
    assign start = (state_q == IDLE) && (bus.req != '0);

    // Round-robin choice of the winner.
    always_comb begin
        win_d = pick_winner(bus.req, ptr_q);
    end

    // The single shared comparator sees only the latched operands.
    cmp2_core #(
        .W (W)
    ) u_core (
        .a   (op_a),
        .b   (op_b),
        .res (core_res)
    );

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: IDLE -> EVAL on a request, then RESP, then back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? EVAL : IDLE;
            EVAL:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant bookkeeping and operand capture on the edge that leaves IDLE.
    // Later operand changes on the bus cannot reach the transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q <= 1'b0;
            ptr_q <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
        end else if (start) begin
            win_q <= win_d;
            ptr_q <= ~win_d;
            op_a  <= win_d ? bus.a1 : bus.a0;
            op_b  <= win_d ? bus.b1 : bus.b0;
        end
    end

    // Result pipeline: compare in EVAL, hold the result on the LEDs after RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= RES_NONE;
            led_q <= RES_NONE;
        end else begin
            if (state_q == EVAL) begin
                res_q <= core_res;
            end
            if (state_q == RESP) begin
                led_q <= res_q;
            end
        end
    end

    // Outputs: gnt in EVAL, done in RESP. The LEDs show the new result
    // during RESP and keep it until the next RESP.
    always_comb begin
        bus.gnt  = '0;
        bus.done = '0;
        led_d    = led_q;
        case (state_q)
            EVAL: bus.gnt[win_q]  = 1'b1;
            RESP: begin
                bus.done[win_q] = 1'b1;
                led_d           = res_q;
            end
            default: ;
        endcase
        bus.green = led_d.gt;
        bus.red   = led_d.lt;
        bus.blue  = led_d.eq;
    end

`ifdef CMP_ARB_STATS_EN
    // Result statistics: one saturating counter per outcome, bumped in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_gt <= '0;
            cnt_lt <= '0;
            cnt_eq <= '0;
        end else if (state_q == RESP) begin
            if (res_q.gt && (cnt_gt != '1)) cnt_gt <= cnt_gt + 1'b1;
            if (res_q.lt && (cnt_lt != '1)) cnt_lt <= cnt_lt + 1'b1;
            if (res_q.eq && (cnt_eq != '1)) cnt_eq <= cnt_eq + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Self-checking bench for cmp_share_arbiter. Define CMP_ARB_STATS_EN to
// build and check the statistics counters too.
module tb_cmp_share_arbiter;
    import cmp_arb_pkg::*;

    localparam int W = 2;
`ifdef CMP_ARB_STATS_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 8;
`endif
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic       clk;
    logic       rst;
    arb_state_t dbg_state;
`ifdef CMP_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_gt;
    logic [CNT_W-1:0] cnt_lt;
    logic [CNT_W-1:0] cnt_eq;
`endif

    cmp_share_arbiter_if #(.W(W)) bus ();

    cmp_share_arbiter #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
`ifdef CMP_ARB_STATS_EN
        ,
        .cnt_gt    (cnt_gt),
        .cnt_lt    (cnt_lt),
        .cnt_eq    (cnt_eq)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counters and reference-model state
    int       checks = 0;
    int       errors = 0;
    logic     last_win;      // requester granted most recently
    logic [2:0] exp_led;     // {green, red, blue} currently expected on display
    int       m_gt, m_lt, m_eq;

    function automatic logic model_winner(input logic [1:0] r);
        if (r == 2'b01) return 1'b0;
        if (r == 2'b10) return 1'b1;
        return ~last_win;    // tie: the one not granted last
    endfunction

    function automatic logic [2:0] model_cmp(input int x, input int y);
        return {x > y, x < y, x == y};
    endfunction

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        last_win = 1'b1;     // requester 0 wins the first tie
        exp_led  = 3'b000;
        m_gt = 0;
        m_lt = 0;
        m_eq = 0;
    endtask

    // One transaction starting in an IDLE cycle (called right after a
    // negedge); ends at the negedge of the following IDLE cycle.
    task automatic run_txn(input logic [1:0] r,
                           input logic [W-1:0] x0, input logic [W-1:0] y0,
                           input logic [W-1:0] x1, input logic [W-1:0] y1,
                           input bit drop_early, input string tag);
        logic       w;
        logic [1:0] oh;
        logic [2:0] exp_res;
        logic [2:0] got;
        bus.req = r;
        bus.a0 = x0; bus.b0 = y0;
        bus.a1 = x1; bus.b1 = y1;
        w  = model_winner(r);
        oh = w ? 2'b10 : 2'b01;
        exp_res = w ? model_cmp(int'(x1), int'(y1)) : model_cmp(int'(x0), int'(y0));
        @(negedge clk);
        checks++;
        if (bus.gnt !== oh) begin
            errors++;
            $display("FAIL %0s gnt got %b exp %b", tag, bus.gnt, oh);
        end
        checks++;
        if (bus.done !== 2'b00) begin
            errors++;
            $display("FAIL %0s done_in_gnt got %b exp 00", tag, bus.done);
        end
        last_win = w;
        bus.req  = r & ~oh;
        if (drop_early) begin
            if (w) begin
                bus.a1 = W'($urandom); bus.b1 = W'($urandom);
            end else begin
                bus.a0 = W'($urandom); bus.b0 = W'($urandom);
            end
        end
        @(negedge clk);
        got = {bus.green, bus.red, bus.blue};
        checks++;
        if (bus.done !== oh) begin
            errors++;
            $display("FAIL %0s done got %b exp %b", tag, bus.done, oh);
        end
        checks++;
        if (bus.gnt !== 2'b00) begin
            errors++;
            $display("FAIL %0s gnt_in_done got %b exp 00", tag, bus.gnt);
        end
        checks++;
        if (got !== exp_res) begin
            errors++;
            $display("FAIL %0s leds got %b exp %b", tag, got, exp_res);
        end
        exp_led = exp_res;
        if (exp_res[2]) m_gt = sat_inc(m_gt);
        if (exp_res[1]) m_lt = sat_inc(m_lt);
        if (exp_res[0]) m_eq = sat_inc(m_eq);
        @(negedge clk);
        got = {bus.green, bus.red, bus.blue};
        checks++;
        if ((bus.gnt !== 2'b00) || (bus.done !== 2'b00)) begin
            errors++;
            $display("FAIL %0s idle gnt=%b done=%b exp 00/00", tag, bus.gnt, bus.done);
        end
        checks++;
        if (got !== exp_led) begin
            errors++;
            $display("FAIL %0s led_hold got %b exp %b", tag, got, exp_led);
        end
    endtask

    // Idle cycles with no request: nothing may pulse and LEDs must hold.
    task automatic idle_cycles(input int n, input string tag);
        logic [2:0] got;
        bus.req = 2'b00;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            got = {bus.green, bus.red, bus.blue};
            checks++;
            if ((bus.gnt !== 2'b00) || (bus.done !== 2'b00) || (got !== exp_led)) begin
                errors++;
                $display("FAIL %0s gnt=%b done=%b leds=%b exp 00/00/%b",
                         tag, bus.gnt, bus.done, got, exp_led);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 2'b00;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ((bus.gnt !== 2'b00) || (bus.done !== 2'b00) ||
            ({bus.green, bus.red, bus.blue} !== 3'b000)) begin
            errors++;
            $display("FAIL reset gnt=%b done=%b leds=%b exp 00/00/000",
                     bus.gnt, bus.done, {bus.green, bus.red, bus.blue});
        end
        rst = 1'b0;
        idle_cycles(2, "reset_idle");
    endtask

    task automatic test_single();
        run_txn(2'b01, 2'd2, 2'd1, 2'd0, 2'd0, 1'b0, "single_gt");
        idle_cycles(3, "hold_gt");
        run_txn(2'b10, 2'd0, 2'd0, 2'd1, 2'd3, 1'b0, "single_lt");
        idle_cycles(2, "hold_lt");
        run_txn(2'b10, 2'd0, 2'd0, 2'd2, 2'd2, 1'b0, "single_eq");
        idle_cycles(2, "hold_eq");
    endtask

    task automatic test_back_to_back();
        // req=11 held throughout: grants alternate 01,10,01,10.
        for (int i = 0; i < 4; i++) begin
            run_txn(2'b11, 2'd3, 2'd3, 2'd3, 2'd3, 1'b0, "b2b");
        end
        idle_cycles(1, "b2b_end");
    endtask

    task automatic test_drop_in_eval();
        run_txn(2'b01, 2'd3, 2'd1, 2'd0, 2'd0, 1'b1, "drop0");
        run_txn(2'b10, 2'd0, 2'd0, 2'd0, 2'd3, 1'b1, "drop1");
        idle_cycles(1, "drop_end");
    endtask

    task automatic test_reset_mid();
        bus.req = 2'b01; bus.a0 = 2'd1; bus.b0 = 2'd2;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 2'b01) begin
            errors++;
            $display("FAIL rst_mid_gnt got %b exp 01", bus.gnt);
        end
        #2;
        rst = 1'b1;
        bus.req = 2'b00;
        model_reset();
        #1;
        checks++;
        if ((bus.gnt !== 2'b00) || (bus.done !== 2'b00) ||
            ({bus.green, bus.red, bus.blue} !== 3'b000)) begin
            errors++;
            $display("FAIL rst_mid gnt=%b done=%b leds=%b exp 00/00/000",
                     bus.gnt, bus.done, {bus.green, bus.red, bus.blue});
        end
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(6, "rst_mid_after");
    endtask

    task automatic test_random();
        logic [1:0] r;
        logic [1:0] pend;
        pend = 2'b00;
        for (int i = 0; i < 40; i++) begin
            r = pend | 2'($urandom_range(0, 3));
            if (r == 2'b00) r = 2'($urandom_range(1, 3));
            run_txn(r, W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                    bit'($urandom_range(0, 1)), "random");
            pend = bus.req;
        end
        // Let any pending requester finish.
        if (pend != 2'b00) begin
            run_txn(pend, W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                    1'b0, "random_tail");
        end
        idle_cycles(2, "random_end");
    endtask

`ifdef CMP_ARB_STATS_EN
    task automatic check_counters(input string tag);
        checks++;
        if ((int'(cnt_gt) != m_gt) || (int'(cnt_lt) != m_lt) || (int'(cnt_eq) != m_eq)) begin
            errors++;
            $display("FAIL %0s cnt gt/lt/eq got %0d/%0d/%0d exp %0d/%0d/%0d",
                     tag, cnt_gt, cnt_lt, cnt_eq, m_gt, m_lt, m_eq);
        end
    endtask

    task automatic test_stats();
        test_reset();
        check_counters("stats_reset");
        for (int i = 0; i < 5; i++) begin
            run_txn(2'b01, 2'd3, 2'd0, 2'd0, 2'd0, 1'b0, "stats_gt");
        end
        check_counters("stats_sat");
        checks++;
        if ((cnt_gt !== 2'd3) || (cnt_lt !== 2'd0) || (cnt_eq !== 2'd0)) begin
            errors++;
            $display("FAIL stats_fixed got %0d/%0d/%0d exp 3/0/0", cnt_gt, cnt_lt, cnt_eq);
        end
        test_random();
        check_counters("stats_random");
    endtask
`endif

    initial begin
        rst = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_drop_in_eval();
        test_reset_mid();
        test_random();
`ifdef CMP_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "time limit reached");
    end

endmodule
